phase_timer: RTL
================

// Module: phase_timer
// PURPOSE
//   Timing responder for the washing-machine controller. Watches the controller's
//   current_state and times each active phase: Filling Water, Washing, Rinsing and Spinning.
//   When a phase's programmed duration elapses, it returns the matching one-hot DoneFlags
//   pulse. It sits between the controller FSM and the machine's tick/clock domain.
// PARAMETERS
//   TICK_DIV     50  clock cycles per time tick (>=1)
//   FILL_TICKS   10  Filling Water duration in ticks
//   WASH_TICKS   20  Washing duration in ticks
//   RINSE_TICKS  10  Rinsing duration in ticks
//   SPIN_TICKS   5   Spinning duration in ticks
//   CNT_W        8   width of tick counter / Time_Left; all *_TICKS < 2**CNT_W
// PORTS
//   CLK            input   1      system clock, rising edge
//   RST            input   1      reset, synchronous, active-high
//   current_state  input   3      controller phase: 000 IDLE, 001 Fill, 010 Wash,
//                                  011 Rinse, 100 Spin, others invalid
//   Pause          input   1      level; freezes timing of the running phase (lid open)
//   DoneFlags      output  4      one-hot done pulse: [3] Fill, [2] Wash, [1] Rinse, [0] Spin
//   Time_Left      output  CNT_W  ticks remaining in the current phase
//   Phase_Active   output  1      high while a phase is being timed and not yet done
// BEHAVIOUR
//   - Reset (RST=1 at CLK edge): DoneFlags=0, Time_Left=0, Phase_Active=0,
//     prescaler=0, prev_state=IDLE, timer FSM=T_IDLE. Reset mid-phase aborts the phase.
//     After release, a non-IDLE current_state counts as a fresh entry.
//   - prev_state register tracks current_state. Entry = current_state != prev_state.
//   - Timer FSM has three states: T_IDLE, T_RUN, T_DONE.
//     T_IDLE: outputs quiet. On entry to a valid phase: load D, clear prescaler, go to T_RUN.
//     T_RUN: prescaler counts 0..TICK_DIV-1 while Pause=0; wrap gives one tick.
//       On each tick, Time_Left decrements. The tick that takes it to 0 drives
//       DoneFlags to the phase bit for exactly 1 cycle, then the FSM goes to T_DONE.
//     T_DONE: DoneFlags=0, Time_Left=0, Phase_Active=0. Stays here until the next entry.
//       No repeat pulse occurs even if the controller never leaves the phase.
//   - Load value D is the parameter for the phase. D=0 is treated as 1.
//     Time_Left=D on the cycle after entry.
//   - Latency: DoneFlags pulse begins exactly D*TICK_DIV cycles after the first cycle
//     in which current_state shows the new phase, with Pause held low. Each paused
//     cycle adds one cycle.
//   - Entry while in T_RUN or T_DONE: the running phase is abandoned with no pulse and
//     the new phase loads immediately. This covers double wash (Rinse->Wash) and
//     re-entry after a controller reset.
//   - Entry to IDLE or to an invalid code: go to T_IDLE, clear the counters,
//     DoneFlags stays 0.
//   - Pause: holds the prescaler and Time_Left. It does not block entry detection,
//     and a phase change while paused still reloads. Pause has no effect in T_IDLE
//     or T_DONE.
//   - Pulse on the same cycle as an entry: entry has priority and the pulse is
//     suppressed.
//   - DoneFlags is registered, at most one bit high, never high for more than 1 cycle.
// TESTING
//   1. TICK_DIV=4, FILL_TICKS=3; IDLE->001 at cycle 0 -> DoneFlags=4'b1000 in cycle 12
//      only; Time_Left 3,2,1,0.
//   2. Full cycle 001->010->011->100, each change 1 cycle after its pulse -> pulses
//      1000, 0100, 0010, 0001 in order at 12, 20+, ... cycles per parameters;
//      back to IDLE gives no pulse.
//   3. Double wash 011->010 on Rinse pulse -> Wash reloads WASH_TICKS and a second
//      0100 pulse follows after WASH_TICKS*TICK_DIV cycles.
//   4. Pause high for 7 cycles mid-Wash -> Time_Left frozen; pulse delayed exactly
//      7 cycles.
//   5. RST=1 for 1 cycle mid-Spin while current_state stays 100 -> outputs 0; Spin
//      re-timed from scratch, with pulse 0001 SPIN_TICKS*TICK_DIV cycles after reset
//      release.
//   6. Hold 001 after pulse for 100 cycles, and drive 3'b111 -> no further DoneFlags;
//      111 gives T_IDLE with all outputs 0.

Source files
------------

// File: rtl/phase_timer.sv
// Phase timer for the washing-machine controller: times Fill/Wash/Rinse/Spin
// phases and returns a one-cycle one-hot DoneFlags pulse when each elapses.
module phase_timer #(
  parameter int TICK_DIV    = 50,
  parameter int FILL_TICKS  = 10,
  parameter int WASH_TICKS  = 20,
  parameter int RINSE_TICKS = 10,
  parameter int SPIN_TICKS  = 5,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       current_state,
  input  logic             Pause,
  output logic [3:0]       DoneFlags,
  output logic [CNT_W-1:0] Time_Left,
  output logic             Phase_Active
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  // The entry cycle itself is prescaler slot 0, so the first registered slot is 1.
  localparam logic [PRE_W-1:0] PRE_ENTRY = (TICK_DIV > 1) ? PRE_W'(1) : '0;

  localparam logic [CNT_W-1:0] FILL_D  = CNT_W'((FILL_TICKS  == 0) ? 1 : FILL_TICKS);
  localparam logic [CNT_W-1:0] WASH_D  = CNT_W'((WASH_TICKS  == 0) ? 1 : WASH_TICKS);
  localparam logic [CNT_W-1:0] RINSE_D = CNT_W'((RINSE_TICKS == 0) ? 1 : RINSE_TICKS);
  localparam logic [CNT_W-1:0] SPIN_D  = CNT_W'((SPIN_TICKS  == 0) ? 1 : SPIN_TICKS);

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tstate_e;

  tstate_e          state, state_nxt;
  logic [2:0]       prev_state;
  logic [PRE_W-1:0] presc, presc_nxt;
  logic [CNT_W-1:0] tl_nxt;
  logic [3:0]       done_nxt;
  logic             entry;

  function automatic logic is_phase(input logic [2:0] ph);
    return (ph >= 3'd1) && (ph <= 3'd4);
  endfunction

  function automatic logic [CNT_W-1:0] load_val(input logic [2:0] ph);
    case (ph)
      3'd1:    return FILL_D;
      3'd2:    return WASH_D;
      3'd3:    return RINSE_D;
      3'd4:    return SPIN_D;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] phase_bit(input logic [2:0] ph);
    case (ph)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= T_IDLE;
      prev_state <= 3'd0;
      presc      <= '0;
      Time_Left  <= '0;
      DoneFlags  <= '0;
    end else begin
      state      <= state_nxt;
      prev_state <= current_state;
      presc      <= presc_nxt;
      Time_Left  <= tl_nxt;
      DoneFlags  <= done_nxt;
    end
  end

  always_comb begin
    entry     = (current_state != prev_state);
    state_nxt = state;
    presc_nxt = presc;
    tl_nxt    = Time_Left;
    done_nxt  = '0;
    if (entry) begin
      // Entry wins over any tick landing in the same cycle.
      if (is_phase(current_state)) begin
        state_nxt = T_RUN;
        tl_nxt    = load_val(current_state);
        presc_nxt = Pause ? '0 : PRE_ENTRY;
      end else begin
        state_nxt = T_IDLE;
        tl_nxt    = '0;
        presc_nxt = '0;
      end
    end else begin
      case (state)
        T_RUN: begin
          if (!Pause) begin
            if (presc == PRE_LAST) begin
              presc_nxt = '0;
              tl_nxt    = Time_Left - CNT_W'(1);
              if (Time_Left == CNT_W'(1)) begin
                done_nxt  = phase_bit(current_state);
                state_nxt = T_DONE;
              end
            end else begin
              presc_nxt = presc + PRE_W'(1);
            end
          end
        end
        T_IDLE, T_DONE: begin
          tl_nxt    = '0;
          presc_nxt = '0;
        end
        default: begin
          state_nxt = T_IDLE;
          tl_nxt    = '0;
          presc_nxt = '0;
        end
      endcase
    end
  end

  assign Phase_Active = (state == T_RUN);

endmodule
